// File: rtl/rf_pkg.sv
// -----------------------------------------------------------------------------
// rf_pkg
// Shared register-file constants and types. Used by the write-port arbiter,
// its scoreboard and the core decode logic.
//   NUM_REGS - number of architectural registers
//   ADDR_W   - register address width
//   DATA_W   - register data width
//   REG_ZERO - hard-wired zero register; writes to it are discarded
// -----------------------------------------------------------------------------
package rf_pkg;

    localparam int NUM_REGS = 32;
    localparam int ADDR_W   = 5;
    localparam int DATA_W   = 32;

    typedef logic [ADDR_W-1:0] addr_t;
    typedef logic [DATA_W-1:0] data_t;

    localparam addr_t REG_ZERO = {ADDR_W{1'b0}};

    // Source currently owning the register-file write port
    typedef enum logic [1:0] {
        GNT_NONE = 2'd0,
        GNT_CORE = 2'd1,
        GNT_BUF  = 2'd2
    } gnt_src_e;

    // True for any register that actually holds state (everything but r0)
    function automatic logic is_real_reg(input addr_t addr);
        return (addr != REG_ZERO);
    endfunction

endpackage

// File: rtl/regfile_wb_arbiter_if.sv
// -----------------------------------------------------------------------------
// regfile_wb_arbiter_if
// Bundles the core writeback, core decode sources, MDU issue/result handshake
// and register-file write port seen by regfile_wb_arbiter.
//   slave  modport : the arbiter (drives mdu_ready, reg_write, write_reg,
//                    write_data, stall, sb_err)
//   master modport : the surrounding core / MDU / register file
// -----------------------------------------------------------------------------
interface regfile_wb_arbiter_if;
    import rf_pkg::*;

    // core writeback and decode
    logic  core_wr_en;
    addr_t core_wr_addr;
    data_t core_wr_data;
    addr_t core_rs;
    addr_t core_rt;

    // MDU issue and result handshake
    logic  mdu_issue;
    addr_t mdu_issue_dst;
    logic  mdu_valid;
    logic  mdu_ready;
    addr_t mdu_addr;
    data_t mdu_data;

    // register-file write port and status back to the core
    logic  reg_write;
    addr_t write_reg;
    data_t write_data;
    logic  stall;
    logic  sb_err;

    modport slave (
        input  core_wr_en, core_wr_addr, core_wr_data, core_rs, core_rt,
        input  mdu_issue, mdu_issue_dst, mdu_valid, mdu_addr, mdu_data,
        output mdu_ready, reg_write, write_reg, write_data, stall, sb_err
    );

    modport master (
        output core_wr_en, core_wr_addr, core_wr_data, core_rs, core_rt,
        output mdu_issue, mdu_issue_dst, mdu_valid, mdu_addr, mdu_data,
        input  mdu_ready, reg_write, write_reg, write_data, stall, sb_err
    );

endinterface

// File: rtl/rf_scoreboard.sv
// -----------------------------------------------------------------------------
// rf_scoreboard
// Busy-register tracking for long-latency MDU destinations.
//   clk, rst          - clock, synchronous active-high reset
//   set_en, set_addr  - MDU issue: mark destination busy (r0 ignored)
//   clr_en, clr_addr  - buffered MDU result drained: mark register free
//   rs, rt            - core decode sources checked for RAW hazards
//   wr_en, wr_addr    - core writeback checked for WAW hazards
//   hazard            - combinational RAW/WAW hazard indication
//   sb_err            - sticky: MDU issued to a register that was still busy
// -----------------------------------------------------------------------------
module rf_scoreboard
    import rf_pkg::*;
(
    input  logic  clk,
    input  logic  rst,
    input  logic  set_en,
    input  addr_t set_addr,
    input  logic  clr_en,
    input  addr_t clr_addr,
    input  addr_t rs,
    input  addr_t rt,
    input  logic  wr_en,
    input  addr_t wr_addr,
    output logic  hazard,
    output logic  sb_err
);

    logic [NUM_REGS-1:0] busy_q;
    logic [NUM_REGS-1:0] busy_d;
    logic                sb_err_q;
    logic                sb_err_d;
    logic                set_real;
    logic                clr_same;

    // Next busy vector and error flag: clear first, then set so set wins
    always_comb begin
        busy_d   = busy_q;
        sb_err_d = sb_err_q;
        set_real = set_en && is_real_reg(set_addr);
        clr_same = clr_en && (clr_addr == set_addr);

        if (clr_en) begin
            busy_d[clr_addr] = 1'b0;
        end else begin
            busy_d = busy_q;
        end

        if (set_real) begin
            busy_d[set_addr] = 1'b1;
            // a register being freed this very cycle is not a double issue
            if (busy_q[set_addr] && !clr_same) begin
                sb_err_d = 1'b1;
            end else begin
                sb_err_d = sb_err_q;
            end
        end else begin
            sb_err_d = sb_err_q;
        end

        busy_d[REG_ZERO] = 1'b0;
    end

    // RAW on either source, WAW on the core destination; r0 never hazards
    always_comb begin
        hazard = (busy_q[rs] && is_real_reg(rs))
               | (busy_q[rt] && is_real_reg(rt))
               | (wr_en && busy_q[wr_addr] && is_real_reg(wr_addr));
    end

    // Busy vector and sticky error register
    always_ff @(posedge clk) begin
        if (rst) begin
            busy_q   <= {NUM_REGS{1'b0}};
            sb_err_q <= 1'b0;
        end else begin
            busy_q   <= busy_d;
            sb_err_q <= sb_err_d;
        end
    end

    assign sb_err = sb_err_q;

endmodule

// File: rtl/regfile_wb_arbiter.sv
// -----------------------------------------------------------------------------
// regfile_wb_arbiter
// Owns the single register-file write port. The core writeback has priority
// and is granted in the same cycle; MDU results land in a one-entry buffer
// and drain whenever the core leaves the port free. A buffer denied the port
// for STARVE_LIMIT cycles stalls the core so it can drain.
//   clk  - clock
//   rst  - synchronous active-high reset; forces reg_write/mdu_ready/stall low
//   bus  - regfile_wb_arbiter_if.slave: core writeback/decode, MDU issue and
//          result handshake, register-file write port, stall, sb_err
// -----------------------------------------------------------------------------
module regfile_wb_arbiter
    import rf_pkg::*;
#(
    parameter int STARVE_LIMIT = 4
)
(
    input  logic                 clk,
    input  logic                 rst,
    regfile_wb_arbiter_if.slave  bus
);

    localparam int             CNT_W      = $clog2(STARVE_LIMIT + 1);
    localparam logic [CNT_W-1:0] STARVE_MAX = CNT_W'(STARVE_LIMIT);

    logic             buf_valid_q;
    logic             buf_valid_d;
    addr_t            buf_addr_q;
    addr_t            buf_addr_d;
    data_t            buf_data_q;
    data_t            buf_data_d;
    logic [CNT_W-1:0] starve_cnt_q;
    logic [CNT_W-1:0] starve_cnt_d;

    logic     mdu_ready;
    logic     accept;
    logic     hazard;
    logic     starve;
    logic     stall_raw;
    logic     core_go;
    logic     drain;
    logic     sb_err;
    gnt_src_e gnt;
    addr_t    sel_addr;
    data_t    sel_data;

    rf_scoreboard u_scoreboard (
        .clk      (clk),
        .rst      (rst),
        .set_en   (bus.mdu_issue),
        .set_addr (bus.mdu_issue_dst),
        .clr_en   (drain),
        .clr_addr (buf_addr_q),
        .rs       (bus.core_rs),
        .rt       (bus.core_rt),
        .wr_en    (bus.core_wr_en),
        .wr_addr  (bus.core_wr_addr),
        .hazard   (hazard),
        .sb_err   (sb_err)
    );

    // Handshake, stall and grant decision; all gated off while in reset
    always_comb begin
        mdu_ready = !rst && !buf_valid_q;
        accept    = bus.mdu_valid && mdu_ready;
        starve    = buf_valid_q && (starve_cnt_q == STARVE_MAX);
        stall_raw = hazard | starve;
        core_go   = !rst && bus.core_wr_en && !stall_raw;
        drain     = !rst && !core_go && buf_valid_q;

        if (core_go) begin
            gnt = GNT_CORE;
        end else if (drain) begin
            gnt = GNT_BUF;
        end else begin
            gnt = GNT_NONE;
        end
    end

    // Write-port mux; idle port drives zeros
    always_comb begin
        case (gnt)
            GNT_CORE: begin
                sel_addr = bus.core_wr_addr;
                sel_data = bus.core_wr_data;
            end
            GNT_BUF: begin
                sel_addr = buf_addr_q;
                sel_data = buf_data_q;
            end
            default: begin
                sel_addr = REG_ZERO;
                sel_data = {DATA_W{1'b0}};
            end
        endcase
    end

    // Buffer load/drain; load needs an empty buffer so it never meets a drain
    always_comb begin
        buf_valid_d = buf_valid_q;
        buf_addr_d  = buf_addr_q;
        buf_data_d  = buf_data_q;
        if (accept) begin
            buf_valid_d = 1'b1;
            buf_addr_d  = bus.mdu_addr;
            buf_data_d  = bus.mdu_data;
        end else if (drain) begin
            buf_valid_d = 1'b0;
        end else begin
            buf_valid_d = buf_valid_q;
        end
    end

    // Count cycles a full buffer is denied the port, saturating at the limit
    always_comb begin
        starve_cnt_d = starve_cnt_q;
        if (!buf_valid_q || drain) begin
            starve_cnt_d = {CNT_W{1'b0}};
        end else if (starve_cnt_q != STARVE_MAX) begin
            starve_cnt_d = starve_cnt_q + CNT_W'(1);
        end else begin
            starve_cnt_d = starve_cnt_q;
        end
    end

    // Buffer and starvation counter registers
    always_ff @(posedge clk) begin
        if (rst) begin
            buf_valid_q  <= 1'b0;
            buf_addr_q   <= REG_ZERO;
            buf_data_q   <= {DATA_W{1'b0}};
            starve_cnt_q <= {CNT_W{1'b0}};
        end else begin
            buf_valid_q  <= buf_valid_d;
            buf_addr_q   <= buf_addr_d;
            buf_data_q   <= buf_data_d;
            starve_cnt_q <= starve_cnt_d;
        end
    end

    assign bus.mdu_ready  = mdu_ready;
    assign bus.stall      = !rst && stall_raw;
    // r0 writes are suppressed but still retire the buffered result
    assign bus.reg_write  = (gnt != GNT_NONE) && is_real_reg(sel_addr);
    assign bus.write_reg  = sel_addr;
    assign bus.write_data = sel_data;
    assign bus.sb_err     = sb_err;

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
module tb_regfile_wb_arbiter;
    import rf_pkg::*;

    localparam int STARVE_LIMIT = 4;
    localparam int NUM_RAND     = 2000;

    typedef struct {
        logic        rst;
        logic        we;
        logic [4:0]  wa;
        logic [31:0] wd;
        logic [4:0]  rs;
        logic [4:0]  rt;
        logic        iss;
        logic [4:0]  idst;
        logic        mv;
        logic [4:0]  ma;
        logic [31:0] md;
        logic        e_ready;
        logic        e_stall;
        logic        e_we;
        logic [4:0]  e_wreg;
        logic [31:0] e_wdata;
        logic        e_err;
    } vec_t;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    regfile_wb_arbiter_if bus();

    regfile_wb_arbiter #(.STARVE_LIMIT(STARVE_LIMIT)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int checks   = 0;
    int failures = 0;

    vec_t vecs[27];
    vec_t cur;

    // reference model state
    bit          mbusy[32];
    bit          mbv;
    logic [4:0]  mba;
    logic [31:0] mbd;
    int          mwait;
    bit          merr;

    // bench-side MDU: ordered list of outstanding destinations
    logic [4:0]  pend_q[$];
    bit          presenting;
    logic [31:0] pres_data;

    function automatic vec_t v(int unsigned a_rst, int unsigned a_we, int unsigned a_wa,
                               int unsigned a_wd, int unsigned a_rs, int unsigned a_rt,
                               int unsigned a_iss, int unsigned a_idst, int unsigned a_mv,
                               int unsigned a_ma, int unsigned a_md, int unsigned e_rdy,
                               int unsigned e_stl, int unsigned e_we, int unsigned e_wr,
                               int unsigned e_wd, int unsigned e_err);
        vec_t r;
        r.rst = 1'(a_rst);   r.we = 1'(a_we);     r.wa = 5'(a_wa);   r.wd = a_wd;
        r.rs = 5'(a_rs);     r.rt = 5'(a_rt);     r.iss = 1'(a_iss); r.idst = 5'(a_idst);
        r.mv = 1'(a_mv);     r.ma = 5'(a_ma);     r.md = a_md;
        r.e_ready = 1'(e_rdy); r.e_stall = 1'(e_stl); r.e_we = 1'(e_we);
        r.e_wreg = 5'(e_wr); r.e_wdata = e_wd;    r.e_err = 1'(e_err);
        return r;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic drive(input vec_t x);
        rst               = x.rst;
        bus.core_wr_en    = x.we;
        bus.core_wr_addr  = x.wa;
        bus.core_wr_data  = x.wd;
        bus.core_rs       = x.rs;
        bus.core_rt       = x.rt;
        bus.mdu_issue     = x.iss;
        bus.mdu_issue_dst = x.idst;
        bus.mdu_valid     = x.mv;
        bus.mdu_addr      = x.ma;
        bus.mdu_data      = x.md;
    endtask

    task automatic check_outputs(input string tag, input vec_t x);
        chk({tag, ".mdu_ready"},  32'(bus.mdu_ready), 32'(x.e_ready));
        chk({tag, ".stall"},      32'(bus.stall),     32'(x.e_stall));
        chk({tag, ".reg_write"},  32'(bus.reg_write), 32'(x.e_we));
        chk({tag, ".write_reg"},  32'(bus.write_reg), 32'(x.e_wreg));
        chk({tag, ".write_data"}, bus.write_data,     x.e_wdata);
        chk({tag, ".sb_err"},     32'(bus.sb_err),    32'(x.e_err));
    endtask

    // Fill expected fields of cur from the model; returns whether the buffer drains
    task automatic model_predict(output bit drained);
        bit hz;
        bit starved;
        drained = 1'b0;
        cur.e_err = merr;
        cur.e_ready = 1'b0; cur.e_stall = 1'b0; cur.e_we = 1'b0;
        cur.e_wreg = 5'd0;  cur.e_wdata = 32'd0;
        if (!cur.rst) begin
            hz = (cur.rs != 5'd0 && mbusy[cur.rs]) || (cur.rt != 5'd0 && mbusy[cur.rt]) ||
                 (cur.we && cur.wa != 5'd0 && mbusy[cur.wa]);
            starved = mbv && (mwait >= STARVE_LIMIT);
            cur.e_stall = hz || starved;
            cur.e_ready = !mbv;
            if (cur.we && !cur.e_stall) begin
                cur.e_we = (cur.wa != 5'd0); cur.e_wreg = cur.wa; cur.e_wdata = cur.wd;
            end else if (mbv) begin
                drained = 1'b1;
                cur.e_we = (mba != 5'd0); cur.e_wreg = mba; cur.e_wdata = mbd;
            end
        end
    endtask

    // Advance the model across one rising edge
    task automatic model_edge(input bit drained);
        bit accepted;
        if (cur.rst) begin
            foreach (mbusy[i]) mbusy[i] = 1'b0;
            mbv = 1'b0; mwait = 0; merr = 1'b0;
        end else begin
            accepted = cur.mv && !mbv;
            if (drained) mbusy[mba] = 1'b0;
            if (cur.iss && cur.idst != 5'd0) begin
                if (mbusy[cur.idst]) merr = 1'b1;
                mbusy[cur.idst] = 1'b1;
            end
            if (!mbv || drained) mwait = 0;
            else if (mwait < STARVE_LIMIT) mwait = mwait + 1;
            if (drained) mbv = 1'b0;
            if (accepted) begin
                mbv = 1'b1; mba = cur.ma; mbd = cur.md;
            end
        end
    endtask

    initial begin
        bit drained;
        bit accepted;

        // order: rst, we,wa,wd, rs,rt, iss,idst, mv,ma,md | ready,stall,we,wreg,wdata, err
        vecs[0]  = v(1, 0,0,0,              0,0, 0,0, 0,0,0,               0,0,0,0,0,               0);
        vecs[1]  = v(0, 1,5,'h11,           0,0, 0,0, 0,0,0,               1,0,1,5,'h11,            0);
        vecs[2]  = v(0, 0,0,0,              0,0, 1,8, 0,0,0,               1,0,0,0,0,               0);
        vecs[3]  = v(0, 0,0,0,              8,0, 0,0, 0,0,0,               1,1,0,0,0,               0);
        vecs[4]  = v(0, 0,0,0,              8,0, 0,0, 1,8,'hDEADBEEF,      1,1,0,0,0,               0);
        vecs[5]  = v(0, 0,0,0,              8,0, 0,0, 0,0,0,               0,1,1,8,'hDEADBEEF,      0);
        vecs[6]  = v(0, 0,0,0,              8,0, 0,0, 0,0,0,               1,0,0,0,0,               0);
        vecs[7]  = v(0, 0,0,0,              0,0, 0,0, 1,9,'h1234,          1,0,0,0,0,               0);
        vecs[8]  = v(0, 1,3,'h30,           0,0, 0,0, 0,0,0,               0,0,1,3,'h30,            0);
        vecs[9]  = v(0, 1,3,'h31,           0,0, 0,0, 0,0,0,               0,0,1,3,'h31,            0);
        vecs[10] = v(0, 1,3,'h32,           0,0, 0,0, 0,0,0,               0,0,1,3,'h32,            0);
        vecs[11] = v(0, 1,3,'h33,           0,0, 0,0, 0,0,0,               0,0,1,3,'h33,            0);
        vecs[12] = v(0, 1,3,'h34,           0,0, 0,0, 0,0,0,               0,1,1,9,'h1234,          0);
        vecs[13] = v(0, 1,3,'h35,           0,0, 0,0, 0,0,0,               1,0,1,3,'h35,            0);
        vecs[14] = v(0, 0,0,0,              0,0, 0,0, 1,0,'hABCD,          1,0,0,0,0,               0);
        vecs[15] = v(0, 0,0,0,              0,0, 0,0, 0,0,0,               0,0,0,0,'hABCD,          0);
        vecs[16] = v(0, 0,0,0,              8,0, 0,0, 0,0,0,               1,0,0,0,0,               0);
        vecs[17] = v(0, 0,0,0,              0,0, 1,8, 0,0,0,               1,0,0,0,0,               0);
        vecs[18] = v(0, 0,0,0,              0,0, 0,0, 1,8,'h88,            1,0,0,0,0,               0);
        vecs[19] = v(0, 0,0,0,              0,0, 1,8, 0,0,0,               0,0,1,8,'h88,            0);
        vecs[20] = v(0, 0,0,0,              0,8, 0,0, 0,0,0,               1,1,0,0,0,               0);
        vecs[21] = v(0, 0,0,0,              8,0, 1,8, 0,0,0,               1,1,0,0,0,               0);
        vecs[22] = v(0, 0,0,0,              8,0, 0,0, 0,0,0,               1,1,0,0,0,               1);
        vecs[23] = v(0, 0,0,0,              0,0, 0,0, 0,0,0,               1,0,0,0,0,               1);
        vecs[24] = v(0, 0,0,0,              0,0, 0,0, 1,12,'hC,            1,0,0,0,0,               1);
        vecs[25] = v(1, 1,7,'h77,           8,0, 0,0, 0,0,0,               0,0,0,0,0,               1);
        vecs[26] = v(0, 0,0,0,              8,0, 0,0, 0,0,0,               1,0,0,0,0,               0);

        cur = v(1, 0,0,0, 0,0, 0,0, 0,0,0, 0,0,0,0,0, 0);
        drive(cur);
        @(posedge clk);
        @(posedge clk);

        // directed table
        for (int i = 0; i < 27; i++) begin
            @(negedge clk);
            drive(vecs[i]);
            #1;
            check_outputs($sformatf("vec%0d", i), vecs[i]);
        end

        // randomized run against the reference model
        foreach (mbusy[i]) mbusy[i] = 1'b0;
        mbv = 1'b0; mba = 5'd0; mbd = 32'd0; mwait = 0; merr = 1'b0;
        presenting = 1'b0; pres_data = 32'd0;
        for (int n = 0; n < NUM_RAND; n++) begin
            @(negedge clk);
            cur.rst  = (n == 0) || ($urandom_range(0, 99) == 0);
            cur.we   = 1'($urandom_range(0, 1));
            cur.wa   = 5'($urandom_range(0, 15));
            cur.wd   = $urandom;
            cur.rs   = 5'($urandom_range(0, 15));
            cur.rt   = 5'($urandom_range(0, 15));
            cur.iss  = (pend_q.size() < 3) && ($urandom_range(0, 5) == 0);
            cur.idst = 5'($urandom_range(0, 15));
            if (!presenting && pend_q.size() > 0 && $urandom_range(0, 2) == 0) begin
                presenting = 1'b1;
                pres_data  = $urandom;
            end
            cur.mv = presenting;
            cur.ma = (pend_q.size() > 0) ? pend_q[0] : 5'd0;
            cur.md = pres_data;
            drive(cur);
            model_predict(drained);
            #1;
            check_outputs($sformatf("rand%0d", n), cur);
            @(posedge clk);
            accepted = cur.mv && cur.e_ready;
            model_edge(drained);
            if (cur.rst) begin
                pend_q.delete();
                presenting = 1'b0;
            end else begin
                if (accepted) begin
                    void'(pend_q.pop_front());
                    presenting = 1'b0;
                end
                if (cur.iss) pend_q.push_back(cur.idst);
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
